bloom_scan_sequencer: RTL and testbench

//  Initiator that drives the page-pattern finder: accepts one scan command (1-4 12-bit patterns),

---
 rtl/bloom_pkg.sv | 32 +++
 rtl/bloom_scan_sequencer_if.sv | 59 +++++
 rtl/bloom_lat_counter.sv | 39 +++
 rtl/bloom_scan_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bloom_scan_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bloom_pkg.sv
// Shared constants and state encoding for the
// bloom page-pattern scan path.
package bloom_pkg;

  localparam int NOP       = 4096;
  localparam int P_SIZE    = 12;
  localparam int PPB       = 64;
  localparam int NOB       = NOP / PPB;
  localparam int B_SIZE    = PPB * P_SIZE;
  localparam int NOB_WIDTH = 6;
  localparam int NOP_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_CAP   = 3'd5,
    ST_PUT   = 3'd6,
    ST_DONE  = 3'd7
  } bloom_state_e;

  typedef logic [P_SIZE-1:0] pat_t;

  function automatic logic np_legal(
    input logic [2:0] np
  );
    return (np != 3'd0) && (np <= 3'd4);
  endfunction

endpackage

// File: rtl/bloom_scan_sequencer_if.sv
// Command, fingerprint-store and finder signals
// of the scan sequencer bundled as one interface.
interface bloom_scan_sequencer_if;
  import bloom_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_np;
  pat_t              cmd_x1;
  pat_t              cmd_x2;
  pat_t              cmd_x3;
  pat_t              cmd_x4;

  logic              mem_rd_en;
  logic [NOB_WIDTH-1:0] mem_rd_addr;
  logic [B_SIZE-1:0] mem_rd_data;

  logic [NOB_WIDTH:0] b_idx;
  logic [B_SIZE-1:0] a;
  pat_t              x1;
  pat_t              x2;
  pat_t              x3;
  pat_t              x4;
  logic [2:0]        num_real_patterns;
  logic              put_global_array;

  logic              busy;
  logic              done;
  logic              err;

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_np,
    input  cmd_x1, cmd_x2, cmd_x3, cmd_x4,
    input  mem_rd_data,
    output cmd_ready,
    output mem_rd_en, mem_rd_addr,
    output b_idx, a,
    output x1, x2, x3, x4,
    output num_real_patterns,
    output put_global_array,
    output busy, done, err
  );

  // host / store / finder side
  modport master (
    output cmd_valid, cmd_np,
    output cmd_x1, cmd_x2, cmd_x3, cmd_x4,
    output mem_rd_data,
    input  cmd_ready,
    input  mem_rd_en, mem_rd_addr,
    input  b_idx, a,
    input  x1, x2, x3, x4,
    input  num_real_patterns,
    input  put_global_array,
    input  busy, done, err
  );

endinterface

// File: rtl/bloom_lat_counter.sv
// Loadable down-counter timing the store read
// latency; zero_o marks the last WAIT cycle.
module bloom_lat_counter #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // load on ISSUE, count down through WAIT
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(LAT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bloom_scan_sequencer.sv
// Walks the fingerprint store block by block and
// feeds each block to the pattern finder.
module bloom_scan_sequencer
  import bloom_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  bloom_scan_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_PRIME = ST_PRIME;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_CAP   = ST_CAP;
  localparam logic [2:0] S_PUT   = ST_PUT;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam logic [NOB_WIDTH-1:0] BLK_LAST =
    NOB_WIDTH'(NOB - 1);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [NOB_WIDTH-1:0] blk_q;
  logic [NOB_WIDTH-1:0] blk_d;
  logic                 bad_q;
  logic                 bad_d;
  logic                 accept;
  logic                 lat_zero;

  logic                 cmd_ready_q;
  logic                 mem_rd_en_q;
  logic [NOB_WIDTH-1:0] rd_addr_q;
  logic                 put_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [NOB_WIDTH:0]   b_idx_q;
  logic [B_SIZE-1:0]    a_q;
  pat_t                 x1_q;
  pat_t                 x2_q;
  pat_t                 x3_q;
  pat_t                 x4_q;
  logic [2:0]           np_q;

  assign accept = cmd_ready_q & bus.cmd_valid;

  bloom_lat_counter #(
    .LAT (MEM_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == S_ISSUE),
    .en_i   (state_q == S_WAIT),
    .zero_o (lat_zero)
  );

  // scan sequencing
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    bad_d   = bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          blk_d   = '0;
          bad_d   = !np_legal(bus.cmd_np);
          state_d = bad_d ? S_DONE : S_PRIME;
        end
      end
      S_PRIME: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_zero) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: state_d = S_CAP;
      S_CAP:  state_d = S_PUT;
      S_PUT: begin
        if (blk_q == BLK_LAST) begin
          state_d = S_DONE;
        end else begin
          blk_d   = blk_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, block pointer and legality flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      bad_q   <= bad_d;
    end
  end

  // latch the command for the whole scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q <= '0;
      x2_q <= '0;
      x3_q <= '0;
      x4_q <= '0;
      np_q <= '0;
    end else if (accept) begin
      x1_q <= bus.cmd_x1;
      x2_q <= bus.cmd_x2;
      x3_q <= bus.cmd_x3;
      x4_q <= bus.cmd_x4;
      np_q <= bus.cmd_np;
    end
  end

  // capture block slice on the last WAIT edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_idx_q <= '0;
    end else if ((state_q == S_WAIT) && lat_zero) begin
      a_q     <= bus.mem_rd_data;
      b_idx_q <= {1'b0, blk_q};
    end
  end

  // registered control outputs, aligned to state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rd_addr_q   <= '0;
      put_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == S_IDLE);
      mem_rd_en_q <= (state_d == S_ISSUE);
      if (state_d == S_ISSUE) begin
        rd_addr_q <= blk_d;
      end
      put_q  <= (state_d == S_PUT);
      busy_q <= (state_d != S_IDLE) &&
                (state_d != S_DONE);
      done_q <= (state_d == S_DONE);
      err_q  <= (state_d == S_DONE) && bad_d;
    end
  end

  assign bus.cmd_ready         = cmd_ready_q;
  assign bus.mem_rd_en         = mem_rd_en_q;
  assign bus.mem_rd_addr       = rd_addr_q;
  assign bus.b_idx             = b_idx_q;
  assign bus.a                 = a_q;
  assign bus.x1                = x1_q;
  assign bus.x2                = x2_q;
  assign bus.x3                = x3_q;
  assign bus.x4                = x4_q;
  assign bus.num_real_patterns = np_q;
  assign bus.put_global_array  = put_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;

  a_stable_a: assert property (
    @(posedge clk) disable iff (!rst)
    ((state_q == S_CAP) || (state_q == S_PUT))
    |-> $stable(a_q)
  );

endmodule

// File: tb/tb_bloom_scan_sequencer.sv
// Scoreboard bench for the bloom scan sequencer
// with a store model and a global-array model.
module tb_bloom_scan_sequencer;
  import bloom_pkg::*;

  localparam int L = 3;
  localparam int SCAN_CYC = 2 + NOB * (4 + L);

  typedef struct {
    logic [6:0]        bi;
    logic [B_SIZE-1:0] a;
    logic [2:0]        np;
    logic [11:0]       x1;
  } blk_exp_t;

  typedef struct {
    bit err;
    int lat;
    int rds;
    int puts;
    bit busy;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bloom_scan_sequencer_if bus();

  bloom_scan_sequencer #(
    .MEM_LAT (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0]       pg [NOP];
  logic [B_SIZE-1:0] pipe [L];

  blk_exp_t  exp_blk[$];
  done_exp_t exp_done[$];
  int        exp_hits[$];
  int        gl[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int acc_n = 0;
  int acc_cnt = 0;
  int rd_cnt = 0;
  int put_cnt = 0;
  int done_cnt = 0;
  bit busy_seen = 0;
  bit prev_put = 0;
  bit prev_done = 0;

  function automatic void check(
    input string nm,
    input logic [B_SIZE-1:0] act,
    input logic [B_SIZE-1:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endfunction

  function automatic logic [B_SIZE-1:0] blk_data(
    input int b
  );
    logic [B_SIZE-1:0] d;
    for (int j = 0; j < PPB; j++)
      d[j*P_SIZE +: P_SIZE] = pg[b*PPB + j];
    return d;
  endfunction

  // fingerprint store with L-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en)
      pipe[0] <= blk_data(int'(bus.mem_rd_addr));
    for (int i = 1; i < L; i++)
      pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rd_data = pipe[L-1];

  // monitor: accept tracking, finder model, checks
  always @(negedge clk) begin
    blk_exp_t    eb;
    done_exp_t   ed;
    logic [11:0] xk [4];
    bit          hit;
    ncyc++;
    if (!rst) begin
      gl.delete();
      prev_put = 0;
      prev_done = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_n = ncyc;
        acc_cnt++;
        rd_cnt = 0;
        put_cnt = 0;
        busy_seen = 0;
      end
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.busy) busy_seen = 1;
      if (bus.put_global_array && !prev_put) begin
        put_cnt++;
        if (exp_blk.size() == 0) begin
          check("put_unexpected", 1, 0);
        end else begin
          eb = exp_blk.pop_front();
          check("b_idx", bus.b_idx, eb.bi);
          check("a", bus.a, eb.a);
          check("np_out", bus.num_real_patterns,
                eb.np);
          check("x1_out", bus.x1, eb.x1);
        end
        xk[0] = bus.x1;
        xk[1] = bus.x2;
        xk[2] = bus.x3;
        xk[3] = bus.x4;
        for (int j = 0; j < PPB; j++) begin
          hit = 0;
          for (int k = 0; k < 4; k++)
            if (k < int'(bus.num_real_patterns) &&
                bus.a[j*P_SIZE +: P_SIZE] == xk[k])
              hit = 1;
          if (hit)
            gl.push_back(int'(bus.b_idx) * PPB + j);
        end
      end
      if (bus.done) begin
        check("done_width", prev_done, 0);
        check("ready_in_done", bus.cmd_ready, 0);
        check("busy_in_done", bus.busy, 0);
        if (exp_done.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          ed = exp_done.pop_front();
          check("err", bus.err, ed.err);
          check("latency", ncyc - acc_n, ed.lat);
          check("reads", rd_cnt, ed.rds);
          check("puts", put_cnt, ed.puts);
          check("busy_seen", busy_seen, ed.busy);
          check("left_blocks", exp_blk.size(), 0);
          if (!ed.err) begin
            check("hit_count", gl.size(),
                  exp_hits.size());
            if (gl.size() == exp_hits.size())
              foreach (gl[i])
                check("hit_page", gl[i], exp_hits[i]);
          end
        end
        done_cnt++;
      end
      prev_put = bus.put_global_array;
      prev_done = bus.done;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_blk.delete();
    exp_done.delete();
    #1;
    check("rst_ctrl",
          {bus.cmd_ready, bus.busy, bus.done,
           bus.err, bus.mem_rd_en,
           bus.put_global_array}, 0);
    check("rst_data",
          {bus.b_idx, bus.num_real_patterns,
           bus.x1, bus.x2, bus.x3, bus.x4,
           bus.mem_rd_addr}, 0);
    check("rst_a", bus.a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", bus.cmd_ready, 1);
  endtask

  task automatic issue(
    input logic [2:0]        np,
    input logic [3:0][11:0]  xs,
    input bit                hold
  );
    bit legal;
    done_exp_t ed;
    legal = (np >= 1 && np <= 4);
    exp_hits.delete();
    if (legal) begin
      for (int b = 0; b < NOB; b++)
        exp_blk.push_back('{7'(b), blk_data(b),
                            np, xs[0]});
      for (int p = 0; p < NOP; p++) begin
        for (int k = 0; k < int'(np); k++)
          if (pg[p] == xs[k]) begin
            exp_hits.push_back(p);
            break;
          end
      end
    end
    ed.err  = !legal;
    ed.lat  = legal ? SCAN_CYC : 1;
    ed.rds  = legal ? NOB : 0;
    ed.puts = legal ? NOB : 0;
    ed.busy = legal;
    exp_done.push_back(ed);
    for (int t = 0; t < 20 && !bus.cmd_ready; t++)
      begin @(posedge clk); #1; end
    check("ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_np = np;
    bus.cmd_x1 = xs[0];
    bus.cmd_x2 = xs[1];
    bus.cmd_x3 = xs[2];
    bus.cmd_x4 = xs[3];
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    for (int t = 0; t < 1000 && done_cnt == start;
         t++)
      @(posedge clk);
    check("done_timeout", done_cnt != start, 1);
  endtask

  task automatic run(
    input logic [2:0]       np,
    input logic [3:0][11:0] xs
  );
    int s;
    s = done_cnt;
    issue(np, xs, 0);
    wait_done(s);
  endtask

  task automatic fill_random();
    for (int p = 0; p < NOP; p++)
      pg[p] = 12'($urandom);
  endtask

  task automatic scrub(input logic [11:0] v);
    for (int p = 0; p < NOP; p++)
      if (pg[p] == v) pg[p] = v ^ 12'h800;
  endtask

  task automatic rand_scan();
    logic [2:0]       np;
    logic [3:0][11:0] xs;
    fill_random();
    np = 3'($urandom_range(1, 4));
    for (int k = 0; k < 4; k++) begin
      xs[k] = 12'($urandom);
      pg[$urandom_range(0, NOP-1)] = xs[k];
    end
    run(np, xs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][11:0] xs;
    int s;
    int acc0;
    bus.cmd_valid = 1'b0;
    bus.cmd_np = '0;
    bus.cmd_x1 = '0;
    bus.cmd_x2 = '0;
    bus.cmd_x3 = '0;
    bus.cmd_x4 = '0;
    fill_random();
    do_reset();

    fill_random();
    scrub(12'hABC);
    pg[70] = 12'hABC;
    xs = {12'h123, 12'h456, 12'h789, 12'hABC};
    run(3'd1, xs);
    check("t1_ret0", gl.size() > 0 ? gl[0] : -1, 70);
    do_reset();

    fill_random();
    scrub(12'h001);
    scrub(12'h002);
    pg[5] = 12'h002;
    pg[4095] = 12'h001;
    xs = {12'h0, 12'h0, 12'h002, 12'h001};
    run(3'd2, xs);
    check("t2_ret1", gl.size() > 1 ? gl[1] : -1,
          4095);
    do_reset();

    run(3'd0, xs);
    do_reset();
    run(3'd5, xs);
    do_reset();

    repeat (2) begin
      rand_scan();
      do_reset();
    end

    fill_random();
    xs = {12'h111, 12'h222, 12'h333, 12'h444};
    pg[20*PPB + 3] = 12'h444;
    issue(3'd3, xs, 0);
    for (int t = 0; t < 3000 && bus.b_idx != 7'd20;
         t++)
      begin @(posedge clk); #1; end
    check("t5_hold_seen", bus.b_idx, 20);
    rst = 1'b0;
    exp_blk.delete();
    exp_done.delete();
    #1;
    check("t5_abort_ctrl",
          {bus.busy, bus.put_global_array,
           bus.mem_rd_en, bus.done}, 0);
    check("t5_abort_a", bus.a, 0);
    @(negedge clk); #1;
    check("t5_gl_cleared", gl.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    rand_scan();
    do_reset();

    fill_random();
    xs = {12'h0, 12'h0, 12'h0, 12'h5A5};
    acc0 = acc_cnt;
    s = done_cnt;
    issue(3'd1, xs, 1);
    wait_done(s);
    #1;
    check("t6_accepts", acc_cnt - acc0, 1);
    check("t6_ready_after_done", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
